sfx_sequencer: RTL and testbench
================================

SFX_SEQUENCER -- requirements
Module: sfx_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_FX, default 3, giving the number of sound effects and trigger inputs.
REQ-002 The block SHALL have parameter NOTES, default 4, giving the notes per effect.
REQ-003 The block SHALL have parameter DIV_W, default 18, giving the width of a half-period count.
REQ-004 The block SHALL have parameter NOTE_CYCLES, default 1_000_000, giving the clock cycles per note.
REQ-005 The block SHALL have parameter FX_TABLE, a flattened NUM_FX*NOTES*DIV_W-bit half-period table; entry (f,n) sits at bits [(f*NOTES+n)*DIV_W +: DIV_W], and value 0 means rest.
REQ-006 Port clk, input, 1 bit: the single system clock.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port trig, input, NUM_FX bits: per-effect trigger level.
REQ-009 Port mute, input, 1 bit: forces buzz low without stopping sequencing.
REQ-010 Port buzz, output, 1 bit: registered square-wave drive.
REQ-011 Port busy, output, 1 bit: high while an effect is playing.
REQ-012 Port active_fx, output, clog2(NUM_FX) bits: index of the effect playing, or last played.
REQ-013 Port done, output, 1 bit: one-cycle pulse on natural completion of an effect.

Function
REQ-014 Triggers SHALL be rising-edge detected per bit against a registered copy of trig, which resets to 0.
REQ-015 When several edges occur in the same cycle, the highest index SHALL win.
REQ-016 While idle, an edge on bit f SHALL start effect f with 1-cycle latency: on the next cycle busy=1, active_fx=f, note index=0, duration counter=0, tone counter=0 and buzz=0.
REQ-017 While busy, an edge with index >= active_fx SHALL preempt, restarting per REQ-016 with the new index, and done SHALL NOT pulse.
REQ-018 While busy, an edge with index < active_fx SHALL be ignored and SHALL NOT be queued.
REQ-019 The tone counter SHALL count 0..H-1 for the current entry H; at H-1 it SHALL clear and toggle the internal tone bit, giving a full period of 2*H cycles.
REQ-020 For H=0 the tone bit SHALL be held at 0.
REQ-021 At every note boundary, the tone counter and tone bit SHALL clear to 0.
REQ-022 The duration counter SHALL count 0..NOTE_CYCLES-1; at NOTE_CYCLES-1 it SHALL clear and advance the note index, so each note lasts exactly NOTE_CYCLES cycles.
REQ-023 At the end of note NOTES-1, on the next cycle busy=0, buzz=0 and done=1 for exactly one cycle; active_fx SHALL hold its value.
REQ-024 An edge in the cycle of the final note's last count SHALL start the new effect per REQ-016, without an idle cycle, and done SHALL still pulse.
REQ-025 buzz SHALL equal the tone bit AND NOT mute AND busy, registered, so muting takes effect 1 cycle later.
REQ-026 mute SHALL NOT alter counters, the note index, busy or done.
REQ-027 Counter widths SHALL be clog2-sized from NOTE_CYCLES, NOTES and DIV_W, and counters SHALL NOT wrap beyond their terminal counts.

Reset
REQ-028 Synchronous reset SHALL set buzz=0, busy=0, done=0, active_fx=0, all counters=0, note index=0 and the trig history=0.
REQ-029 Reset SHALL take priority over triggers in the same cycle.
REQ-030 Reset mid-effect SHALL abort the effect with no done pulse.
REQ-031 A trig bit held high through reset release SHALL start its effect on the first cycle after release.

Verification (NUM_FX=3, NOTES=2, NOTE_CYCLES=8, DIV_W=4, table fx0={2,0}, fx1={1,3}, fx2={4,4})
REQ-032 Pulse trig[0] one cycle -> busy for 16 cycles; buzz toggles every 2 cycles for 8 cycles, then stays 0 for 8; done pulses once; active_fx=0.
REQ-033 Start fx1, then pulse trig[0] at cycle 5 -> ignored; fx1 completes at cycle 16 with done=1.
REQ-034 Start fx0, then pulse trig[2] at cycle 5 -> restarts with active_fx=2 and note 0; no done from fx0; busy for 16 more cycles.
REQ-035 Assert trig=3'b011 in one cycle -> fx1 plays.
REQ-036 Hold mute for the whole fx2 effect -> buzz=0 throughout; busy and done timing are identical to unmuted.
REQ-037 Assert reset at cycle 6 of fx1 -> next cycle busy=0, buzz=0, with no done pulse.

Source files
------------

// File: rtl/sfx_sequencer.sv
// Multi-effect sound sequencer: rising edges on trig start table-driven note
// sequences, which drive a registered square wave on buzz.
module sfx_sequencer #(
  parameter int NUM_FX      = 3,
  parameter int NOTES       = 4,
  parameter int DIV_W       = 18,
  parameter int NOTE_CYCLES = 1_000_000,
  parameter logic [NUM_FX*NOTES*DIV_W-1:0] FX_TABLE = '0,
  localparam int FX_W = (NUM_FX > 1) ? $clog2(NUM_FX) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_FX-1:0] trig,
  input  logic              mute,
  output logic              buzz,
  output logic              busy,
  output logic [FX_W-1:0]   active_fx,
  output logic              done
);

  localparam int DUR_W  = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam int NOTE_W = (NOTES > 1) ? $clog2(NOTES) : 1;

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t            state;
  logic [NUM_FX-1:0] trig_q;
  logic [NUM_FX-1:0] rise;
  logic              any_rise;
  logic [FX_W-1:0]   win;
  logic [DUR_W-1:0]  dur_cnt;
  logic [NOTE_W-1:0] note_idx;
  logic [DIV_W-1:0]  tone_cnt;
  logic [DIV_W-1:0]  half;
  logic              tone;
  logic              note_end;
  logic              fx_end;
  logic              start;

  assign busy = (state == S_PLAY);

  always_comb begin
    rise     = trig & ~trig_q;
    any_rise = |rise;
    win      = '0;
    for (int unsigned i = 0; i < NUM_FX; i++) begin
      if (rise[i]) win = FX_W'(i);
    end
    note_end = (dur_cnt == DUR_W'(NOTE_CYCLES - 1));
    fx_end   = busy && note_end && (note_idx == NOTE_W'(NOTES - 1));
    // A finishing effect no longer blocks lower-index triggers, so back-to-back starts need no idle cycle.
    start    = any_rise && (!busy || fx_end || (win >= active_fx));
    half     = FX_TABLE[(int'(active_fx) * NOTES + int'(note_idx)) * DIV_W +: DIV_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      trig_q    <= '0;
      active_fx <= '0;
      dur_cnt   <= '0;
      note_idx  <= '0;
      tone_cnt  <= '0;
      tone      <= 1'b0;
      buzz      <= 1'b0;
      done      <= 1'b0;
    end else begin
      trig_q <= trig;
      done   <= fx_end;
      if (start) begin
        state     <= S_PLAY;
        active_fx <= win;
        dur_cnt   <= '0;
        note_idx  <= '0;
        tone_cnt  <= '0;
        tone      <= 1'b0;
        buzz      <= 1'b0;
      end else if (fx_end) begin
        state    <= S_IDLE;
        dur_cnt  <= '0;
        note_idx <= '0;
        tone_cnt <= '0;
        tone     <= 1'b0;
        buzz     <= 1'b0;
      end else if (busy) begin
        buzz <= tone & ~mute;
        if (note_end) begin
          dur_cnt  <= '0;
          note_idx <= note_idx + 1'b1;
          tone_cnt <= '0;
          tone     <= 1'b0;
        end else begin
          dur_cnt <= dur_cnt + 1'b1;
          if (half == '0) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
          end else if (tone_cnt == half - DIV_W'(1)) begin
            tone_cnt <= '0;
            tone     <= ~tone;
          end else begin
            tone_cnt <= tone_cnt + 1'b1;
          end
        end
      end else begin
        buzz <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios plus random triggers, checked
// cycle by cycle against an elapsed-time reference model.
module tb_sfx_sequencer;

  localparam int NC = 8;
  localparam int NN = 2;
  localparam int L  = NC * NN;
  localparam logic [23:0] TABLE = {4'd4, 4'd4, 4'd3, 4'd1, 4'd0, 4'd2};

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] trig;
  logic       mute;
  logic       buzz;
  logic       busy;
  logic [1:0] active_fx;
  logic       done;

  int checks = 0;
  int errors = 0;

  int         tbl [3][2] = '{'{2, 0}, '{1, 3}, '{4, 4}};
  int         cyc  = 0;
  int         m_st = 0;
  int         m_fx = 0;
  bit         m_busy = 0;
  bit         m_done = 0;
  bit         m_buzz = 0;
  logic [2:0] m_prev = '0;

  sfx_sequencer #(
    .NUM_FX(3),
    .NOTES(NN),
    .DIV_W(4),
    .NOTE_CYCLES(NC),
    .FX_TABLE(TABLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trig(trig),
    .mute(mute),
    .buzz(buzz),
    .busy(busy),
    .active_fx(active_fx),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic bit tone_at(int f, int e);
    int h;
    h = tbl[f][e / NC];
    if (h == 0) return 1'b0;
    return bit'(((e % NC) / h) % 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] t, input logic m, input logic r);
    logic [2:0] rs;
    int win;
    int ep;
    bit fin;
    trig  = t;
    mute  = m;
    reset = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_busy = 0; m_fx = 0; m_done = 0; m_buzz = 0; m_prev = '0;
    end else begin
      rs  = t & ~m_prev;
      win = -1;
      for (int i = 0; i < 3; i++) if (rs[i]) win = i;
      ep  = cyc - 1 - m_st;
      fin = m_busy && (ep == L - 1);
      m_buzz = m_busy && !fin && !m && tone_at(m_fx, ep);
      m_done = fin;
      if (win >= 0 && (!m_busy || fin || win >= m_fx)) begin
        m_busy = 1; m_fx = win; m_st = cyc; m_buzz = 0;
      end else if (fin) begin
        m_busy = 0;
      end
      m_prev = t;
    end
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("active_fx", 32'(active_fx), 32'(m_fx));
    chk("done", 32'(done), 32'(m_done));
    chk("buzz", 32'(buzz), 32'(m_buzz));
  endtask

  task automatic idle(input int n, input logic m);
    for (int i = 0; i < n; i++) step(3'b000, m, 1'b0);
  endtask

  initial begin
    logic [2:0] rt;
    logic       rm;
    trig = '0; mute = 1'b0; reset = 1'b1;
    // reset state
    repeat (3) step(3'b000, 1'b0, 1'b1);
    // single fx0 pulse
    step(3'b001, 1'b0, 1'b0);
    idle(20, 1'b0);
    // lower-index trigger ignored during fx1
    step(3'b010, 1'b0, 1'b0);
    idle(4, 1'b0);
    step(3'b001, 1'b0, 1'b0);
    idle(20, 1'b0);
    // higher-index preemption
    step(3'b001, 1'b0, 1'b0);
    idle(4, 1'b0);
    step(3'b100, 1'b0, 1'b0);
    idle(20, 1'b0);
    // simultaneous edges
    step(3'b011, 1'b0, 1'b0);
    idle(20, 1'b0);
    // muted fx2
    step(3'b100, 1'b1, 1'b0);
    idle(20, 1'b1);
    // reset mid-effect
    step(3'b010, 1'b0, 1'b0);
    idle(5, 1'b0);
    step(3'b000, 1'b0, 1'b1);
    idle(3, 1'b0);
    // edge on the final count of the last note
    step(3'b001, 1'b0, 1'b0);
    idle(15, 1'b0);
    step(3'b010, 1'b0, 1'b0);
    idle(20, 1'b0);
    // trig held through reset release, reset beats edge
    step(3'b100, 1'b0, 1'b1);
    step(3'b100, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(3'b100, 1'b0, 1'b0);
    idle(2, 1'b0);
    // random traffic
    rm = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rt = ($urandom_range(0, 9) < 2) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 15) == 0) rm = ~rm;
      step(rt, rm, ($urandom_range(0, 199) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
